// File: rtl/maze_pkg.sv
// Shared types for the maze DFS solver: move directions, FSM states and the
// direction-reversal helper used when backtracking.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROBE  = 3'd1,
        EVAL   = 3'd2,
        POP    = 3'd3,
        DONE   = 3'd4,
        REPLAY = 3'd5,
        END    = 3'd6,
        FAIL   = 3'd7
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_DOWN:  return DIR_UP;
            DIR_RIGHT: return DIR_LEFT;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_DOWN;
        endcase
    endfunction

endpackage

// File: rtl/dir_stack.sv
// Bounded stack of 2-bit moves with an extra random read port used to replay
// the stored path from the bottom up.
module dir_stack
    import maze_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned SP_W        = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  dir_t            push_dir,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output dir_t            top,
    input  logic [SP_W-1:0] rd_idx,
    output dir_t            rd_dir
);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    dir_t mem [STACK_DEPTH];

    assign full   = (sp == SP_W'(STACK_DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[IDX_W'(sp - SP_W'(1))];
    assign rd_dir = mem[IDX_W'(rd_idx)];

    // Storage needs no reset: entries are only read below sp.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[IDX_W'(sp)] <= push_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver over a DIM x DIM wall memory, (0,0) to (DIM-1,DIM-1),
// with path replay. Define PATH_LEN_EN to expose the current path length.
module maze_dfs_solver
    import maze_pkg::*;
#(
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned SP_W        = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic                 Run,
    output logic [2*COORD_W-1:0] mem_addr,
    input  logic                 mem_data,
    output logic                 Fail,
    output logic                 Done,
    output logic                 The_End,
    output logic [2*COORD_W-1:0] Move,
    output logic                 move_valid
`ifdef PATH_LEN_EN
    ,
    output logic [SP_W-1:0]      path_len
`endif
);
    localparam int unsigned ADDR_W = 2 * COORD_W;
    localparam int unsigned CELLS  = 2 ** ADDR_W;
    localparam logic [COORD_W-1:0] EDGE_HI = '1;
    localparam logic [ADDR_W-1:0]  TARGET  = '1;

    state_t               state, state_n;
    logic [ADDR_W-1:0]    pos, pos_n, rpos, rpos_n, nb_addr;
    logic [2:0]           try_dir, dir_n;
    logic [SP_W-1:0]      ridx, ridx_n, sp;
    logic [CELLS-1:0]     visited;
    logic [COORD_W-1:0]   row, col;
    logic                 in_rng, nb_ok, clear_vis, mark_vis, push, pop, full, empty;
    dir_t                 cur_dir, top, rd_dir;

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] p, input dir_t d);
        logic [COORD_W-1:0] r;
        logic [COORD_W-1:0] c;
        r = p[ADDR_W-1:COORD_W];
        c = p[COORD_W-1:0];
        case (d)
            DIR_DOWN:  r = r + COORD_W'(1);
            DIR_RIGHT: c = c + COORD_W'(1);
            DIR_LEFT:  c = c - COORD_W'(1);
            default:   r = r - COORD_W'(1);
        endcase
        return {r, c};
    endfunction

    dir_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .SP_W       (SP_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .push_dir(cur_dir),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .top     (top),
        .rd_idx  (ridx),
        .rd_dir  (rd_dir)
    );

    assign cur_dir = dir_t'(try_dir[1:0]);
    assign row     = pos[ADDR_W-1:COORD_W];
    assign col     = pos[COORD_W-1:0];

    // Edge check happens before the step so coordinates never wrap.
    always_comb begin
        in_rng = 1'b0;
        case (cur_dir)
            DIR_DOWN:  in_rng = (row != EDGE_HI);
            DIR_RIGHT: in_rng = (col != EDGE_HI);
            DIR_LEFT:  in_rng = (col != '0);
            default:   in_rng = (row != '0);
        endcase
        nb_addr = step(pos, cur_dir);
        nb_ok   = !try_dir[2] && in_rng && !visited[nb_addr];
    end

    assign mem_addr = (state == PROBE && nb_ok) ? nb_addr : '0;

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        dir_n     = try_dir;
        rpos_n    = rpos;
        ridx_n    = ridx;
        push      = 1'b0;
        pop       = 1'b0;
        clear_vis = 1'b0;
        mark_vis  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_n   = PROBE;
                    pos_n     = '0;
                    dir_n     = '0;
                    clear_vis = 1'b1;
                end
            end
            PROBE: begin
                if (try_dir[2]) begin
                    state_n = empty ? FAIL : POP;
                end else if (!nb_ok) begin
                    dir_n = try_dir + 3'd1;
                end else begin
                    state_n = EVAL;
                end
            end
            EVAL: begin
                if (mem_data) begin
                    dir_n   = try_dir + 3'd1;
                    state_n = PROBE;
                end else if (full) begin
                    state_n = FAIL;
                end else begin
                    push     = 1'b1;
                    mark_vis = 1'b1;
                    pos_n    = nb_addr;
                    dir_n    = '0;
                    state_n  = (nb_addr == TARGET) ? DONE : PROBE;
                end
            end
            POP: begin
                pop     = 1'b1;
                pos_n   = step(pos, opposite(top));
                dir_n   = {1'b0, top} + 3'd1;
                state_n = PROBE;
            end
            DONE: begin
                if (Run) begin
                    state_n = REPLAY;
                    rpos_n  = '0;
                    ridx_n  = '0;
                end
            end
            REPLAY: begin
                if (ridx == sp) begin
                    state_n = END;
                end else begin
                    rpos_n = step(rpos, rd_dir);
                    ridx_n = ridx + SP_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            try_dir    <= '0;
            rpos       <= '0;
            ridx       <= '0;
            visited    <= '0;
            Fail       <= 1'b0;
            Done       <= 1'b0;
            The_End    <= 1'b0;
            Move       <= '0;
            move_valid <= 1'b0;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            try_dir <= dir_n;
            rpos    <= rpos_n;
            ridx    <= ridx_n;
            if (clear_vis) begin
                visited <= CELLS'(1);
            end else if (mark_vis) begin
                visited[nb_addr] <= 1'b1;
            end
            Fail       <= (state_n == FAIL);
            Done       <= (state_n == DONE) || (state_n == END);
            The_End    <= (state_n == END);
            move_valid <= (state_n == REPLAY);
            if (state_n == REPLAY) begin
                Move <= rpos_n;
            end
        end
    end

`ifdef PATH_LEN_EN
    assign path_len = sp;
`endif

endmodule

// File: tb/tb_maze_dfs_solver.sv
// Self-checking bench: a reference DFS model queues expected reads, latency and
// replay cells; monitors and per-scenario tasks compare the DUT against them.
module tb_maze_dfs_solver;

    logic       clk = 1'b0;
    logic       rst, start, run, mem_data, fail, done, the_end, move_valid;
    logic [3:0] mem_addr, move;
    logic [15:0] maze;
    logic       o_start, o_run, o_mem_data, o_fail, o_done, o_the_end, o_move_valid;
    logic [3:0] o_mem_addr, o_move;
`ifdef PATH_LEN_EN
    logic [4:0] path_len;
    logic [2:0] o_path_len;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b1;
    int exp_reads [$];
    int exp_moves [$];
    bit m_ok;
    int m_cycles, m_len;

    always #5 clk = ~clk;

    maze_dfs_solver #(.COORD_W(2), .STACK_DEPTH(16), .SP_W(5)) u_dut (
        .clk(clk), .rst(rst), .Start(start), .Run(run),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .Fail(fail), .Done(done), .The_End(the_end),
        .Move(move), .move_valid(move_valid)
`ifdef PATH_LEN_EN
        , .path_len(path_len)
`endif
    );

    maze_dfs_solver #(.COORD_W(2), .STACK_DEPTH(4), .SP_W(3)) u_ovf (
        .clk(clk), .rst(rst), .Start(o_start), .Run(o_run),
        .mem_addr(o_mem_addr), .mem_data(o_mem_data),
        .Fail(o_fail), .Done(o_done), .The_End(o_the_end),
        .Move(o_move), .move_valid(o_move_valid)
`ifdef PATH_LEN_EN
        , .path_len(o_path_len)
`endif
    );

    // Synchronous maze memories: data one cycle after the address.
    always @(posedge clk) begin
        mem_data   <= maze[mem_addr];
        o_mem_data <= 1'b0;
    end

    // Every nonzero address is a read; it must match the next queued one.
    always @(negedge clk) begin : read_mon
        int e;
        if (mon_en && mem_addr != 4'd0) begin
            n_cmp++;
            if (exp_reads.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: got addr %0h, none expected", mem_addr);
            end else begin
                e = exp_reads.pop_front();
                if (mem_addr !== 4'(e)) begin
                    n_bad++;
                    $display("FAIL read_addr: got %0h want %0h", mem_addr, e);
                end
            end
        end
    end

    task automatic model_dfs(input logic [15:0] mz, input int depth);
        bit vis [16];
        int stk [$];
        int r, c, d, nr, nc, a;
        bit stop;
        exp_reads.delete();
        exp_moves.delete();
        for (int k = 0; k < 16; k++) vis[k] = 1'b0;
        vis[0] = 1'b1;
        r = 0; c = 0; d = 0; stop = 1'b0; m_ok = 1'b0; m_cycles = 1;
        while (!stop) begin
            if (d == 4) begin
                m_cycles++;
                if (stk.size() == 0) stop = 1'b1;
                else begin
                    m_cycles++;
                    d = stk.pop_back();
                    case (d)
                        0: r = r - 1;
                        1: c = c - 1;
                        2: c = c + 1;
                        default: r = r + 1;
                    endcase
                    d = d + 1;
                end
            end else begin
                nr = r + ((d == 0) ? 1 : (d == 3) ? -1 : 0);
                nc = c + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
                a  = nr * 4 + nc;
                if (nr < 0 || nr > 3 || nc < 0 || nc > 3) begin
                    m_cycles++; d = d + 1;
                end else if (vis[a]) begin
                    m_cycles++; d = d + 1;
                end else begin
                    exp_reads.push_back(a);
                    m_cycles += 2;
                    if (mz[a]) d = d + 1;
                    else if (stk.size() == depth) stop = 1'b1;
                    else begin
                        stk.push_back(d);
                        r = nr; c = nc; vis[a] = 1'b1; d = 0;
                        if (a == 15) begin m_ok = 1'b1; stop = 1'b1; end
                    end
                end
            end
        end
        m_len = stk.size();
        if (m_ok) begin
            r = 0; c = 0;
            exp_moves.push_back(0);
            foreach (stk[k]) begin
                case (stk[k])
                    0: r = r + 1;
                    1: c = c + 1;
                    2: c = c - 1;
                    default: r = r - 1;
                endcase
                exp_moves.push_back(r * 4 + c);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // noisy: Start stays high and Run toggles during the search.
    task automatic run_search(input logic [15:0] mz, input bit noisy);
        int cyc;
        maze = mz;
        model_dfs(mz, 16);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = noisy; cyc = 1;
        while (!(done || fail) && cyc < 300) begin
            if (noisy) run = (cyc >= 2 && cyc <= 4);
            n_cmp++;
            if (move_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL early_replay: move_valid %b at cycle %0d want 0", move_valid, cyc);
            end
            @(negedge clk); cyc++;
        end
        run = 1'b0;
        n_cmp++;
        if (done !== m_ok || fail !== !m_ok) begin
            n_bad++;
            $display("FAIL outcome: done=%b fail=%b want done=%b fail=%b", done, fail, m_ok, !m_ok);
        end
        n_cmp++;
        if (cyc !== m_cycles) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, m_cycles);
        end
        n_cmp++;
        if (exp_reads.size() != 0) begin
            n_bad++;
            $display("FAIL reads_missing: %0d outstanding want 0", exp_reads.size());
        end
`ifdef PATH_LEN_EN
        n_cmp++;
        if (path_len !== 5'(m_len)) begin
            n_bad++;
            $display("FAIL path_len: got %0d want %0d", path_len, m_len);
        end
`endif
    endtask

    task automatic replay_check();
        int e;
        int g;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        g = 0;
        while (exp_moves.size() > 0 && g < 64) begin
            n_cmp++;
            if (move_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL replay_valid: got %b want 1 with %0d moves left", move_valid, exp_moves.size());
                exp_moves.delete();
            end else begin
                e = exp_moves.pop_front();
                if (move !== 4'(e)) begin
                    n_bad++;
                    $display("FAIL replay_move: got %0h want %0h", move, e);
                end
            end
            @(negedge clk); g++;
        end
        n_cmp++;
        if ({the_end, done, move_valid, move} !== {1'b1, 1'b1, 1'b0, 4'hF}) begin
            n_bad++;
            $display("FAIL end_state: end=%b done=%b valid=%b move=%0h want 1 1 0 f",
                     the_end, done, move_valid, move);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({fail, done, the_end, move_valid, move, mem_addr,
                 o_fail, o_done, o_the_end, o_move_valid, o_move, o_mem_addr} !== 22'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %b %b %b %b %0h %0h want all 0",
                         fail, done, the_end, move_valid, move, mem_addr);
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_searches();
        run_search(16'h0000, 1'b0);
        replay_check();
        do_reset();
        run_search(16'h0012, 1'b0);
        n_cmp++;
        if (m_cycles > 10 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL blocked_fast: done=%b model cycles %0d want done 0 within 10", done, m_cycles);
        end
        do_reset();
        run_search(16'h0D48, 1'b0);
        replay_check();
        do_reset();
        run_search(16'h2220, 1'b0);
        replay_check();
        do_reset();
    endtask

    task automatic test_overflow();
        int cyc;
        model_dfs(16'h0000, 4);
        exp_reads.delete();
        @(negedge clk); o_start = 1'b1;
        @(negedge clk); o_start = 1'b0; cyc = 1;
        while (!(o_done || o_fail) && cyc < 300) begin
            @(negedge clk); cyc++;
        end
        n_cmp++;
        if (o_fail !== 1'b1 || cyc !== m_cycles) begin
            n_bad++;
            $display("FAIL overflow: fail=%b after %0d cycles want 1 after %0d", o_fail, cyc, m_cycles);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({o_fail, o_done, o_move_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL overflow_hold: fail=%b done=%b valid=%b want 1 0 0", o_fail, o_done, o_move_valid);
        end
`ifdef PATH_LEN_EN
        n_cmp++;
        if (o_path_len !== 3'd4) begin
            n_bad++;
            $display("FAIL overflow_len: got %0d want 4", o_path_len);
        end
`endif
    endtask

    task automatic test_reset_mid();
        mon_en = 1'b0;
        maze = 16'h0000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (mem_addr !== 4'h4) begin
            n_bad++;
            $display("FAIL probe_addr: got %0h want 4", mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({fail, done, the_end, move_valid, move, mem_addr} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_in_probe: addr=%0h done=%b want all 0", mem_addr, done);
        end
        @(negedge clk); rst = 1'b0;
        mon_en = 1'b1;
        run_search(16'h0000, 1'b0);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (move_valid !== 1'b1 || move !== 4'h4) begin
            n_bad++;
            $display("FAIL replay_mid: valid=%b move=%0h want 1 4", move_valid, move);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({fail, done, the_end, move_valid, move, mem_addr} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_in_replay: valid=%b move=%0h done=%b want all 0", move_valid, move, done);
        end
`ifdef PATH_LEN_EN
        n_cmp++;
        if (path_len !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_path_len: got %0d want 0", path_len);
        end
`endif
        @(negedge clk); rst = 1'b0;
        run_search(16'h0000, 1'b0);
        replay_check();
        do_reset();
    endtask

    task automatic test_ignore_inputs();
        run_search(16'h0000, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({done, move_valid, fail, the_end} !== 4'b1000) begin
            n_bad++;
            $display("FAIL done_hold: done=%b valid=%b fail=%b end=%b want 1 0 0 0",
                     done, move_valid, fail, the_end);
        end
        replay_check();
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({the_end, done, move_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL end_hold: end=%b done=%b valid=%b want 1 1 0", the_end, done, move_valid);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; run = 1'b0; maze = 16'h0;
        o_start = 1'b0; o_run = 1'b0;
        test_reset();
        test_overflow();
        test_searches();
        test_reset_mid();
        test_ignore_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
